// File: rtl/multicycle_controller.sv
// Multicycle RV32I-subset control unit: Moore main FSM plus ALU decoder.
// Drives the shared ALU, IR, PC and memory port of the multicycle datapath.
module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BEQ      = 4'd9;
    localparam logic [3:0] JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0] next_state;
    logic [1:0] aluop;
    logic       branch;
    logic       pcupdate;
    logic       legal;

    always_ff @(posedge clk) begin
        if (reset) state <= RESET_STATE;
        else       state <= next_state;
    end

    assign legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                   (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_R:         next_state = EXECUTER;
                    OP_I:         next_state = EXECUTEI;
                    OP_BEQ:       next_state = BEQ;
                    OP_JAL:       next_state = JAL;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  next_state = MEMWB;
            EXECUTER: next_state = ALUWB;
            EXECUTEI: next_state = ALUWB;
            JAL:      next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
    end

    // Moore outputs; unreachable codes fall to the all-zero default
    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        RegWrite  = 1'b0;
        aluop     = 2'b00;
        branch    = 1'b0;
        pcupdate  = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcupdate  = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB: RegWrite = 1'b1;
            BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCWrite    = pcupdate | (branch & zero);
    assign illegal_op = (state == DECODE) && !legal;

    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected control words per cycle
// are pushed to a scoreboard queue and compared against the DUT outputs.
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       rw;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       ill;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;
    ctl_t sb_q[$];
    string tag;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Reference control word for a given (expected) state and inputs
    function automatic ctl_t expect_ctl(input logic [3:0] s, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7,
                                        input logic z);
        ctl_t e;
        logic [1:0] aop;
        logic br, pcu, lg;
        e = '0;
        aop = 2'b00;
        br = 1'b0;
        pcu = 1'b0;
        e.st = s;
        case (s)
            4'd0: begin e.irw = 1; e.sb = 2'b10; e.rs = 2'b10; pcu = 1; end
            4'd1: begin e.sa = 2'b01; e.sb = 2'b01; end
            4'd2: begin e.sa = 2'b10; e.sb = 2'b01; end
            4'd3: e.adr = 1;
            4'd4: begin e.rs = 2'b01; e.rw = 1; end
            4'd5: begin e.adr = 1; e.mw = 1; end
            4'd6: begin e.sa = 2'b10; aop = 2'b10; end
            4'd7: begin e.sa = 2'b10; e.sb = 2'b01; aop = 2'b10; end
            4'd8: e.rw = 1;
            4'd9: begin e.sa = 2'b10; aop = 2'b01; br = 1; end
            4'd10: begin e.sa = 2'b01; e.sb = 2'b10; pcu = 1; end
            default: ;
        endcase
        e.pcw = pcu | (br & z);
        if (aop == 2'b00) e.alu = 3'b000;
        else if (aop == 2'b01) e.alu = 3'b001;
        else if (f3 == 3'b000) e.alu = (f7 && o[5]) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) e.alu = 3'b101;
        else if (f3 == 3'b110) e.alu = 3'b011;
        else if (f3 == 3'b111) e.alu = 3'b010;
        else e.alu = 3'b000;
        if (o == 7'b0100011) e.imm = 2'b01;
        else if (o == 7'b1100011) e.imm = 2'b10;
        else if (o == 7'b1101111) e.imm = 2'b11;
        else e.imm = 2'b00;
        lg = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
             (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
        e.ill = (s == 4'd1) && !lg;
        return e;
    endfunction

    // One cycle: push expectation, sample mid-cycle, advance past the edge
    task automatic cyc(input logic [3:0] s);
        ctl_t e;
        ctl_t obs;
        sb_q.push_back(expect_ctl(s, op, funct3, funct7b5, zero));
        #3;
        obs = {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, RegWrite, ImmSrc, ALUControl, illegal_op};
        e = sb_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s st%0d observed=%h expected=%h", tag, s, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input string t, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic z, input int n,
                         input logic [19:0] seq);
        tag = t;
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        zero = z;
        for (int i = 0; i < n; i++) cyc(seq[4*i +: 4]);
    endtask

    initial begin
        reset = 1'b1;
        op = 7'b0000011;
        funct3 = 3'b000;
        funct7b5 = 1'b0;
        zero = 1'b0;
        @(posedge clk);
        #1;
        tag = "reset";
        cyc(4'd0);
        reset = 1'b0;

        instr("lw", 7'b0000011, 3'b010, 0, 0, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0});
        instr("sw", 7'b0100011, 3'b010, 0, 0, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0});
        instr("sub", 7'b0110011, 3'b000, 1, 0, 4, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0});
        instr("add", 7'b0110011, 3'b000, 0, 0, 4, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0});
        instr("addi", 7'b0010011, 3'b000, 1, 0, 4, {4'd0, 4'd8, 4'd7, 4'd1, 4'd0});
        instr("beq_t", 7'b1100011, 3'b000, 0, 1, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0});
        instr("beq_nt", 7'b1100011, 3'b000, 0, 0, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0});
        instr("jal", 7'b1101111, 3'b000, 0, 1, 4, {4'd0, 4'd8, 4'd10, 4'd1, 4'd0});
        instr("illegal", 7'b1111111, 3'b000, 0, 0, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0});
        instr("slt", 7'b0110011, 3'b010, 0, 0, 4, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0});
        instr("or", 7'b0110011, 3'b110, 0, 0, 4, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0});
        instr("and", 7'b0110011, 3'b111, 1, 0, 4, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0});
        instr("sll", 7'b0110011, 3'b001, 0, 0, 4, {4'd0, 4'd8, 4'd6, 4'd1, 4'd0});
        instr("slti", 7'b0010011, 3'b010, 0, 0, 4, {4'd0, 4'd8, 4'd7, 4'd1, 4'd0});

        instr("lw_rst", 7'b0000011, 3'b010, 0, 0, 3, {4'd0, 4'd0, 4'd2, 4'd1, 4'd0});
        reset = 1'b1;
        tag = "mid_rst";
        cyc(4'd3);
        cyc(4'd0);
        reset = 1'b0;
        instr("post_rst", 7'b0100011, 3'b010, 0, 0, 5, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I-subset core: lw, sw, R-type, I-type ALU, beq, jal.
- A Moore main FSM sequences the shared ALU, instruction register, PC and memory port through fetch, decode and execute cycles.
- Also produces the 3-bit ALU control word from ALUOp, funct3, funct7b5 and op[5], with the same encoding the ALU already uses.
- Sits between the instruction register and the multicycle datapath.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); must remain FETCH in production builds.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  7  instruction opcode field, from the IR.
- funct3  input  3  instruction funct3 field.
- funct7b5  input  1  instruction bit 30.
- zero  input  1  ALU zero flag, valid in the BEQ state.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  data memory write strobe.
- IRWrite  output  1  IR and OldPC load enable.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  output  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- RegWrite  output  1  register file write enable.
- ImmSrc  output  2  00 = I, 01 = S, 10 = B, 11 = J; decoded from op only.
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- illegal_op  output  1  one-cycle pulse in DECODE when op is unsupported.
- state  output  4  current state, for debug.

Behaviour:
- State register (4 bits) updates on posedge clk. If reset = 1, the next state is FETCH regardless of the current state, including mid-instruction.
- All controls are combinational from state, plus op, funct3, funct7b5 and zero. Controls not listed for a state are 0.
- FETCH (0): IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
- DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00.
- MEMREAD (3): ResultSrc=00, AdrSrc=1.
- MEMWB (4): ResultSrc=01, RegWrite=1.
- MEMWRITE (5): ResultSrc=00, AdrSrc=1, MemWrite=1.
- EXECUTER (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- EXECUTEI (7): ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- ALUWB (8): ResultSrc=00, RegWrite=1.
- BEQ (9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
- JAL (10): ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Codes 11-15 are unreachable; if entered, go to FETCH next cycle with all controls 0.
- PCWrite = PCUpdate | (Branch & zero).
- Transitions:
  - FETCH -> DECODE.
  - DECODE on op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other -> FETCH with illegal_op=1 for that cycle.
  - MEMADR: op=0000011 -> MEMREAD, otherwise -> MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH.
  - BEQ -> FETCH.
  - JAL -> ALUWB.
- Instruction cycle counts including FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- ALUControl decode:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10/11, by funct3: 000 -> 001 if (funct7b5 & op[5]) else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other -> 000 (never X).
- ImmSrc by op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, all others -> 00.
- Reset state, held while reset=1: state=0 (FETCH), illegal_op=0. Outputs therefore equal FETCH values: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all other controls 0.

Test Plan:
- Reset asserted for 2 cycles mid-MEMREAD -> state=0 next edge; IRWrite=1, PCWrite=1, ALUControl=000.
- lw (op=0000011) -> state sequence 0,1,2,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01; AdrSrc=1 in state 3.
- sub R-type (op=0110011, funct3=000, funct7b5=1) -> states 0,1,6,8,0; ALUControl=001 in state 6. Same instruction with funct7b5=0 -> 000. addi (op=0010011, funct7b5=1) -> ALUControl=000 in state 7.
- beq with zero=1 -> PCWrite=1 in state 9. With zero=0 -> PCWrite=0. Both cases: ALUControl=001, next state 0.
- jal (op=1101111) -> states 0,1,10,8,0; PCWrite=1 in state 10; ImmSrc=11.
- op=1111111 -> illegal_op=1 in DECODE, FETCH next cycle. slt/or/and R-type -> ALUControl 101/011/010; funct3=001 -> 000.
